// File: rtl/crc_frame_ctrl.sv
// Frame controller for a bit-serial CRC engine: accepts a byte stream, feeds it
// MSB first to the engine and captures the finished CRC at the end of the frame.
module crc_frame_ctrl #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_mode,
  input  logic [15:0]      cfg_poly,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             start,
  input  logic             abort,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_data,
  output logic             crc_init,
  output logic             crc_valid,
  output logic             crc_data,
  output logic             crc_mode,
  output logic [15:0]      crc_poly,
  input  logic [15:0]      crc_in,
  output logic             busy,
  output logic             done,
  output logic [15:0]      result
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_LOAD,
    ST_SHIFT,
    ST_SETTLE,
    ST_DONE
  } state_t;

  state_t           r_state;
  logic             r_mode;
  logic [15:0]      r_poly;
  logic [LEN_W-1:0] r_remain;
  logic [7:0]       r_shift;
  logic [2:0]       r_bitCnt;
  logic [15:0]      r_result;
  logic             r_sReady;
  logic             r_crcInit;
  logic             r_crcValid;
  logic             r_crcData;
  logic             r_busy;
  logic             r_done;

  // Outputs are registered alongside the state so each one is set on entry to its state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_mode     <= 1'b0;
      r_poly     <= 16'h0000;
      r_remain   <= '0;
      r_shift    <= 8'h00;
      r_bitCnt   <= 3'd0;
      r_result   <= 16'h0000;
      r_sReady   <= 1'b0;
      r_crcInit  <= 1'b0;
      r_crcValid <= 1'b0;
      r_crcData  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else if (r_state != ST_IDLE && abort) begin
      r_state    <= ST_IDLE;
      r_sReady   <= 1'b0;
      r_crcInit  <= 1'b0;
      r_crcValid <= 1'b0;
      r_crcData  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start && !abort) begin
            r_mode    <= cfg_mode;
            r_poly    <= cfg_poly;
            r_remain  <= frame_len;
            r_crcInit <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= ST_INIT;
          end
        end
        ST_INIT: begin
          r_crcInit <= 1'b0;
          if (r_remain != '0) begin
            r_sReady <= 1'b1;
            r_state  <= ST_LOAD;
          end else begin
            r_state <= ST_SETTLE;
          end
        end
        ST_LOAD: begin
          if (s_valid) begin
            r_sReady   <= 1'b0;
            r_shift    <= {s_data[6:0], 1'b0};
            r_crcValid <= 1'b1;
            r_crcData  <= s_data[7];
            r_bitCnt   <= 3'd0;
            r_remain   <= r_remain - LEN_W'(1);
            r_state    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // Last bit goes straight back to LOAD so a held s_valid costs only one cycle per byte.
          if (r_bitCnt == 3'd7) begin
            r_crcValid <= 1'b0;
            r_crcData  <= 1'b0;
            if (r_remain != '0) begin
              r_sReady <= 1'b1;
              r_state  <= ST_LOAD;
            end else begin
              r_state <= ST_SETTLE;
            end
          end else begin
            r_crcData <= r_shift[7];
            r_shift   <= {r_shift[6:0], 1'b0};
            r_bitCnt  <= r_bitCnt + 3'd1;
          end
        end
        ST_SETTLE: begin
          r_result <= r_mode ? crc_in : {8'h00, crc_in[7:0]};
          r_done   <= 1'b1;
          r_state  <= ST_DONE;
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign s_ready   = r_sReady;
  assign crc_init  = r_crcInit;
  assign crc_valid = r_crcValid;
  assign crc_data  = r_crcData;
  assign crc_mode  = r_mode;
  assign crc_poly  = r_poly;
  assign busy      = r_busy;
  assign done      = r_done;
  assign result    = r_result;

endmodule

// File: tb/tb_crc_frame_ctrl.sv
// Bench for crc_frame_ctrl: a behavioural serial CRC engine closes the loop and a
// byte-wise CRC model provides the expected results for directed and random frames.
module tb_crc_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_mode;
  logic [15:0] cfg_poly;
  logic [7:0]  frame_len;
  logic        start;
  logic        abort;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        crc_init;
  logic        crc_valid;
  logic        crc_data;
  logic        crc_mode;
  logic [15:0] crc_poly;
  logic [15:0] crc_in;
  logic        busy;
  logic        done;
  logic [15:0] result;

  int total = 0;
  int bad = 0;
  int doneCount = 0;
  int validCount = 0;
  int invBad = 0;
  int idx;
  int doneBefore;
  int curLen;
  logic        expMode;
  logic [15:0] expPoly;
  logic [15:0] lastRes;
  logic [15:0] eng;
  logic [7:0]  frameBytes [256];

  crc_frame_ctrl #(.LEN_W(8)) dut (
    .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_poly(cfg_poly),
    .frame_len(frame_len), .start(start), .abort(abort),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .crc_init(crc_init), .crc_valid(crc_valid), .crc_data(crc_data),
    .crc_mode(crc_mode), .crc_poly(crc_poly), .crc_in(crc_in),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // Serial engine: init 0, MSB first, no reflection, no final XOR.
  always @(posedge clk) begin
    if (rst || crc_init) eng <= 16'h0000;
    else if (crc_valid) begin
      if (crc_mode)
        eng <= {eng[14:0], 1'b0} ^ ((eng[15] ^ crc_data) ? crc_poly : 16'h0000);
      else
        eng <= {8'h00, eng[6:0], 1'b0} ^ ((eng[7] ^ crc_data) ? {8'h00, crc_poly[7:0]} : 16'h0000);
    end
  end
  assign crc_in = eng;

  // Invariant and event monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) doneCount++;
      if (crc_valid) validCount++;
      if (crc_valid && crc_init) invBad++;
      if (!crc_valid && crc_data) invBad++;
      if (s_ready && !busy) invBad++;
      if (busy && (crc_poly != expPoly || crc_mode != expMode)) invBad++;
    end
  end

  function automatic logic [15:0] refCrc(input logic mode, input logic [15:0] poly, input int len);
    int unsigned w = mode ? 16 : 8;
    int unsigned mask = mode ? 32'hFFFF : 32'h00FF;
    int unsigned top = 32'd1 << (w - 1);
    int unsigned c = 0;
    for (int i = 0; i < len; i++) begin
      c = c ^ (32'(frameBytes[i]) << (w - 8));
      for (int b = 0; b < 8; b++) begin
        if ((c & top) != 0) c = ((c << 1) ^ 32'(poly)) & mask;
        else c = (c << 1) & mask;
      end
    end
    return c[15:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %h, need %h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fillRandom(input int len);
    for (int i = 0; i < len; i++) frameBytes[i] = 8'($urandom);
  endtask

  task automatic startFrame(input logic mode, input logic [15:0] poly, input int len);
    cfg_mode   = mode;
    cfg_poly   = poly;
    frame_len  = 8'(len);
    expMode    = mode;
    expPoly    = poly;
    curLen     = len;
    idx        = 0;
    doneBefore = doneCount;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  // One cycle of the byte source; gapPct is the chance of withholding s_valid.
  task automatic applyStimulus(input int gapPct);
    logic accept;
    s_valid = (idx < curLen) && ($urandom_range(99) >= gapPct);
    s_data  = s_valid ? frameBytes[idx] : 8'($urandom);
    accept  = s_valid && s_ready;
    tick();
    if (accept) idx++;
  endtask

  task automatic finishFrame(input string tag, input int gapPct);
    int guard = 0;
    logic [15:0] expRes = refCrc(expMode, expPoly, curLen);
    while (!done && guard < 5000) begin
      applyStimulus(gapPct);
      guard++;
    end
    s_valid = 1'b0;
    checkOutput({tag, " done"}, 16'(done), 16'd1);
    checkOutput({tag, " result"}, result, expRes);
    checkOutput({tag, " bytes"}, 16'(idx), 16'(curLen));
    tick();
    checkOutput({tag, " done count"}, 16'(doneCount - doneBefore), 16'd1);
    checkOutput({tag, " idle"}, 16'(busy), 16'd0);
    lastRes = expRes;
  endtask

  initial begin
    logic [7:0] pat;
    int vBefore;
    rst = 1'b1; cfg_mode = 1'b0; cfg_poly = 16'h0; frame_len = 8'd0;
    start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = 8'h00;
    expMode = 1'b0; expPoly = 16'h0; curLen = 0; idx = 0; lastRes = 16'h0;
    tick(); tick();
    checkOutput("reset ctl", 16'({s_ready, crc_init, crc_valid, crc_data, crc_mode, busy, done}), 16'd0);
    checkOutput("reset poly", crc_poly, 16'h0000);
    checkOutput("reset result", result, 16'h0000);
    rst = 1'b0;
    tick();
    checkOutput("idle after reset", 16'(busy), 16'd0);

    // abort together with start in IDLE must not start a frame
    start = 1'b1; abort = 1'b1; cfg_poly = 16'h1234;
    tick();
    start = 1'b0; abort = 1'b0;
    checkOutput("start+abort ignored", 16'(busy), 16'd0);

    // single byte timing
    frameBytes[0] = 8'hA5; pat = 8'hA5;
    startFrame(1'b0, 16'h0007, 1);
    checkOutput("init pulse", 16'({crc_init, s_ready}), 16'b10);
    s_valid = 1'b1; s_data = 8'hA5;
    tick();
    checkOutput("load ready", 16'(s_ready), 16'd1);
    tick();
    s_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("shift bit %0d", k), 16'({crc_valid, crc_data}), 16'({1'b1, pat[7-k]}));
      tick();
    end
    checkOutput("settle", 16'({crc_valid, done, busy}), 16'b001);
    tick();
    checkOutput("single done", 16'(done), 16'd1);
    checkOutput("single result", result, refCrc(1'b0, 16'h0007, 1));
    tick();
    checkOutput("single done count", 16'(doneCount - doneBefore), 16'd1);
    lastRes = refCrc(1'b0, 16'h0007, 1);

    // CRC-8 check vector
    for (int i = 0; i < 9; i++) frameBytes[i] = 8'h31 + 8'(i);
    startFrame(1'b0, 16'h0007, 9);
    finishFrame("crc8", 0);
    checkOutput("crc8 vector", result, 16'h00F4);

    // CRC-16 check vector with a 5-cycle source stall
    startFrame(1'b1, 16'h8005, 9);
    while (idx < 4) applyStimulus(0);
    repeat (5) applyStimulus(100);
    finishFrame("crc16", 0);
    checkOutput("crc16 vector", result, 16'hFEE8);

    // zero length
    vBefore = validCount;
    startFrame(1'b1, 16'h1021, 0);
    checkOutput("zero init", 16'({crc_init, done}), 16'b10);
    tick();
    checkOutput("zero settle", 16'(done), 16'd0);
    tick();
    checkOutput("zero done", 16'(done), 16'd1);
    checkOutput("zero result", result, 16'h0000);
    tick();
    checkOutput("zero no valid", 16'(validCount - vBefore), 16'd0);
    checkOutput("zero done count", 16'(doneCount - doneBefore), 16'd1);
    lastRes = 16'h0000;

    // abort in the 4th shift cycle of byte 2, then restart
    for (int i = 0; i < 9; i++) frameBytes[i] = 8'h31 + 8'(i);
    startFrame(1'b1, 16'h8005, 9);
    repeat (14) applyStimulus(0);
    checkOutput("pre-abort shifting", 16'({crc_valid, 8'(idx)}), 16'h0102);
    abort = 1'b1; s_valid = 1'b0;
    tick();
    abort = 1'b0;
    checkOutput("abort idle", 16'({busy, crc_valid, s_ready, done}), 16'd0);
    checkOutput("abort result kept", result, lastRes);
    tick(); tick();
    checkOutput("abort no done", 16'(doneCount - doneBefore), 16'd0);
    startFrame(1'b1, 16'h8005, 9);
    finishFrame("restart", 0);

    // abort wins over a LOAD handshake
    startFrame(1'b0, 16'h0031, 3);
    s_valid = 1'b1; s_data = frameBytes[0];
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0; s_valid = 1'b0;
    checkOutput("abort in load", 16'({busy, crc_valid}), 16'd0);
    checkOutput("abort load result", result, lastRes);

    // start and cfg changes mid-frame are ignored
    fillRandom(4);
    startFrame(1'b1, 16'h1021, 4);
    repeat (5) applyStimulus(0);
    start = 1'b1; cfg_poly = 16'hFFFF; cfg_mode = 1'b0; frame_len = 8'd0;
    repeat (3) applyStimulus(0);
    start = 1'b0;
    checkOutput("poly held", crc_poly, 16'h1021);
    finishFrame("ignored start", 0);

    // reset mid-frame
    fillRandom(5);
    startFrame(1'b1, 16'h8005, 5);
    repeat (12) applyStimulus(0);
    rst = 1'b1; s_valid = 1'b0;
    tick();
    checkOutput("midreset ctl", 16'({s_ready, crc_init, crc_valid, crc_data, crc_mode, busy, done}), 16'd0);
    checkOutput("midreset poly", crc_poly, 16'h0000);
    checkOutput("midreset result", result, 16'h0000);
    rst = 1'b0; expMode = 1'b0; expPoly = 16'h0; lastRes = 16'h0;
    doneBefore = doneCount;
    repeat (3) tick();
    checkOutput("midreset no done", 16'(doneCount - doneBefore), 16'd0);

    // maximum length frame
    fillRandom(255);
    startFrame(1'b1, 16'hC867, 255);
    finishFrame("max len", 0);

    // random frames
    for (int n = 0; n < 25; n++) begin
      int len = $urandom_range(12);
      fillRandom(len);
      startFrame(1'($urandom), 16'($urandom), len);
      finishFrame($sformatf("rand %0d", n), $urandom_range(50));
    end

    checkOutput("invariants", 16'(invBad), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
